// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low g..a patterns for hex digits 0..F (dp bit kept separately).
    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  mask;
    } disp_set_t;

    localparam disp_set_t DISP_RST = '{data: 32'h0, dp: 8'h00, mask: 8'hFF};

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment (g..a) lookup.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = FONT[nib];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner with per-slot blanking and
// frame-synchronous double-buffered display registers.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_mask,
    input  logic        load,
    output logic [2:0]  digit_num,
    output logic [7:0]  seg_out,
    output logic        frame_done
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       digit_q, digit_d;
    scan_state_t      state_q, state_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_done_q, frame_done_d;
    disp_set_t        pending_q, pending_d;
    disp_set_t        shadow_q, shadow_d;

    logic             slot_wrap;
    logic             frame_wrap;
    disp_set_t        load_set;
    logic [3:0]       nib_c;
    logic [6:0]       font_c;

    hex_to_seg u_hex_to_seg (
        .nib   (nib_c),
        .seg_c (font_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            digit_q      <= 3'd0;
            state_q      <= BLANK;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
            pending_q    <= DISP_RST;
            shadow_q     <= DISP_RST;
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_q      <= digit_d;
            state_q      <= state_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
        end
    end

    // Segment pattern is computed from next-cycle state so it blanks on the
    // same edge that moves the digit select.
    always_comb begin
        div_cnt_d    = div_cnt_q + DIV_W'(1);
        digit_d      = digit_q;
        state_d      = state_q;
        pending_d    = pending_q;
        shadow_d     = shadow_q;
        seg_d        = SEG_OFF;
        load_set     = '{data: data_in, dp: dp_in, mask: en_mask};

        slot_wrap    = (div_cnt_q == DIV_LAST);
        frame_wrap   = slot_wrap && (digit_q == 3'd7);
        frame_done_d = frame_wrap;

        if (slot_wrap) begin
            div_cnt_d = '0;
            digit_d   = digit_q + 3'd1;
        end

        unique case (state_q)
            BLANK:   if (div_cnt_d == BLANK_END) state_d = SHOW;
            SHOW:    if (slot_wrap)              state_d = BLANK;
            default: state_d = BLANK;
        endcase

        if (load) begin
            pending_d = load_set;
        end
        if (frame_wrap) begin
            shadow_d = load ? load_set : pending_q;
        end

        nib_c = shadow_d.data[{digit_d, 2'b00} +: 4];
        if (state_d == SHOW && shadow_d.mask[digit_d]) begin
            seg_d = {~shadow_d.dp[digit_d], font_c};
        end
    end

    assign digit_num  = digit_q;
    assign seg_out    = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed scan controller for the board's 8-digit seven-segment display. It holds a 32-bit value as eight hex nibbles and steps a digit index through 0..7 at a programmable rate, with a blanking interval at the start of each digit slot. For each slot it drives the active-low segment pattern. It sits directly upstream of the 3-to-8 digit-select decoder: `digit_num` feeds the decoder's index input, and `seg_out` goes straight to the segment pins.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot; must be at least 2.
- `BLANK_CYCLES`, default 1000: cycles at the start of each slot with segments forced off; must satisfy 1 ≤ `BLANK_CYCLES` < `SCAN_DIV`.
- `clk` input, 1: system clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `data_in` input, 32: display value; nibble k is shown on digit k.
- `dp_in` input, 8: decimal points; bit k = 1 lights the dp of digit k.
- `en_mask` input, 8: digit enable; bit k = 0 blanks digit k for its whole slot.
- `load` input, 1: one-cycle strobe that captures `data_in`, `dp_in` and `en_mask`.
- `digit_num` output, 3: current digit index, registered; goes to the select decoder.
- `seg_out` output, 8: active-low segment pattern; [7] = dp, [6:0] = g..a.
- `frame_done` output, 1: one-cycle pulse on the cycle `digit_num` wraps 7→0.

## Operation
- The block has a pending register set and a shadow register set, each covering data, dp and mask.
  - `load` writes the pending set.
  - The shadow set is the one that is displayed. It copies the pending set only at a frame wrap, so no frame ever mixes two values.
  - If `load` and a wrap fall on the same cycle, the shadow set takes `data_in`/`dp_in`/`en_mask` directly, and the pending set takes them too.
- The prescaler `div_cnt` counts 0..`SCAN_DIV`-1 and is `$clog2(SCAN_DIV)` bits wide.
  - At terminal count it returns to 0 and `digit_num` increments modulo 8; 7→0 is the frame wrap.
- The state machine has two states, BLANK and SHOW.
  - BLANK lasts while `div_cnt` < `BLANK_CYCLES`, and `seg_out` = 8'hFF.
  - SHOW covers the rest of the slot. `seg_out` = {~dp, font(nibble)} when `en_mask[digit_num]` = 1, else 8'hFF.
  - BLANK→SHOW occurs when `div_cnt` reaches `BLANK_CYCLES`; SHOW→BLANK occurs at slot wrap.
- Disabled digits are still scanned, so the slot timing and brightness of the other digits do not change.
- Font, with dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Reset values:
  - `div_cnt` = 0, `digit_num` = 0, state = BLANK.
  - `seg_out` = 8'hFF, `frame_done` = 0.
  - Pending and shadow data = 0, dp = 0, mask = 8'hFF.
- Reset asserted mid-slot takes effect immediately: all outputs go to their reset values asynchronously. After deassertion the scan restarts at digit 0 in BLANK.

## Timing
- All outputs are registered.
- `digit_num` and the BLANK state change on the same edge, so the segments are always off when the select line switches. This prevents ghosting.
- Slot length is exactly `SCAN_DIV` cycles; frame length is 8·`SCAN_DIV`.
- A `load` becomes visible at the next frame wrap: latency is at most 8·`SCAN_DIV` cycles and at least 1.
- `frame_done` is high for exactly one cycle per frame, on the edge where `digit_num` becomes 0. It is not asserted on the first slot after reset.

## Structure
- Package `seg_pkg` holds the 16-entry font constants, `SEG_OFF` = 8'hFF, and the state enum {BLANK, SHOW}.
- Sub-module `hex_to_seg` is the combinational nibble→7-bit font lookup. Its output is registered in the parent.
- The block does not instantiate the select decoder; the top level wires `digit_num` to it.

## Test plan
Run the bench with `SCAN_DIV`=4 and `BLANK_CYCLES`=1.
- **Reset:** hold `rst_n`=0 for 3 cycles → `seg_out`=FF, `digit_num`=0, `frame_done`=0; after release, `digit_num` advances every 4 cycles and wraps after 32.
- **Digit values:** `load` with `data_in`=32'h76543210, `dp_in`=0, `en_mask`=FF, then run 2 frames → in the second frame's SHOW cycles, digits 0..7 show C0, F9, A4, B0, 99, 92, 82, F8, and every slot's first cycle shows FF.
- **Mask and dp:** `en_mask`=8'b1111_1110, `dp_in`=8'h02, `data_in`=32'h00000088 → digit 0 is FF for its whole slot; digit 1 shows 00 (8 with dp).
- **Load timing:** a `load` mid-frame leaves the current frame's remaining digits at the old value and shows the new value from digit 0 of the next frame. A `load` on the wrap cycle shows the new value in the frame that starts on that same edge.
- **Async reset:** assert `rst_n` in the SHOW phase of digit 5 → `seg_out`=FF and `digit_num`=0 immediately, without waiting for `clk`; shadow data is 0 after release (digit 0 shows C0).
